// File: rtl/serial_subtractor_nbit.sv
// Bit-serial ripple subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// A start/busy/done handshake frames each WIDTH-cycle operation.
module serial_subtractor_nbit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             d;
  logic             br_next;

  // One full-subtractor cell; res_next already holds the current bit so the
  // completing edge can publish the whole result without an extra cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    d        = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    res_next = res_sh >> 1;
    res_next[WIDTH-1] = d;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      br         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= borrow_in;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          br     <= br_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            diff       <= res_next;
            borrow_out <= br_next;
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Directed and swept checks of serial_subtractor_nbit at WIDTH=4, plus WIDTH=1 and WIDTH=8 copies.
module tb_serial_subtractor_nbit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       start1, bin1, busy1, done1, bout1;
  logic [0:0] a1, b1, diff1;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  serial_subtractor_nbit #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bout4));
  serial_subtractor_nbit #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .borrow_in(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bout1));
  serial_subtractor_nbit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bout8));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic cur_done(input int sel);
    return (sel == 1) ? done1 : (sel == 8) ? done8 : done4;
  endfunction

  function automatic logic cur_busy(input int sel);
    return (sel == 1) ? busy1 : (sel == 8) ? busy8 : busy4;
  endfunction

  // Reference: modular difference, borrow iff a < b + borrow_in.
  function automatic logic [8:0] ref_sub(input int w, input int ra, input int rb, input int rc);
    int r;
    r = (ra - rb - rc) & ((1 << w) - 1);
    return {(ra < rb + rc) ? 1'b1 : 1'b0, r[7:0]};
  endfunction

  // Pulse start for one edge, then wait (bounded) for done; lat counts edges after acceptance.
  task automatic op(input int sel, input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                    output logic [7:0] rd, output logic rb, output int lat, output int bcnt);
    @(negedge clk);
    case (sel)
      1:       begin a1 = ta[0:0]; b1 = tb_v[0:0]; bin1 = tc; start1 = 1'b1; end
      8:       begin a8 = ta;      b8 = tb_v;      bin8 = tc; start8 = 1'b1; end
      default: begin a4 = ta[3:0]; b4 = tb_v[3:0]; bin4 = tc; start4 = 1'b1; end
    endcase
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0; start8 = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!cur_done(sel) && lat < 40) begin
      if (cur_busy(sel)) bcnt++;
      @(negedge clk);
      lat++;
    end
    case (sel)
      1:       begin rd = {7'b0, diff1}; rb = bout1; end
      8:       begin rd = diff8;         rb = bout8; end
      default: begin rd = {4'b0, diff4}; rb = bout4; end
    endcase
    @(negedge clk);
    check("done_single_cycle", {31'b0, cur_done(sel)}, 32'd0);
  endtask

  logic [7:0] rd;
  logic       rb;
  logic [8:0] exp9;
  int         lat, bcnt, prev, ndone;

  initial begin
    vecs[0]  = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0};
    vecs[1]  = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1};
    vecs[2]  = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
    vecs[3]  = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vecs[4]  = '{4'h7, 4'h7, 1'b0, 4'h0, 1'b0};
    vecs[5]  = '{4'h8, 4'h1, 1'b1, 4'h6, 1'b0};
    vecs[6]  = '{4'h0, 4'h1, 1'b0, 4'hF, 1'b1};
    vecs[7]  = '{4'hF, 4'h0, 1'b0, 4'hF, 1'b0};
    vecs[8]  = '{4'h5, 4'h2, 1'b0, 4'h3, 1'b0};
    vecs[9]  = '{4'hA, 4'h5, 1'b1, 4'h4, 1'b0};
    vecs[10] = '{4'h1, 4'h2, 1'b1, 4'hE, 1'b1};

    reset = 1'b1;
    start4 = 1'b0; start1 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; bin4 = 1'b0;
    a1 = '0; b1 = '0; bin1 = 1'b0;
    a8 = '0; b8 = '0; bin8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'b0, busy4}, 32'd0);
    check("reset_done", {31'b0, done4}, 32'd0);
    check("reset_diff", {28'b0, diff4}, 32'd0);
    check("reset_bout", {31'b0, bout4}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      op(4, {4'b0, vecs[i].a}, {4'b0, vecs[i].b}, vecs[i].bin, rd, rb, lat, bcnt);
      check("vec_diff", {24'b0, rd}, {28'b0, vecs[i].diff});
      check("vec_bout", {31'b0, rb}, {31'b0, vecs[i].bout});
      check("vec_latency", lat, 32'd4);
      check("vec_busy_cycles", bcnt, 32'd4);
    end

    // Start held high: back-to-back results, done pulses WIDTH+2 apart.
    @(negedge clk);
    a4 = 4'h5; b4 = 4'h2; bin4 = 1'b0; start4 = 1'b1;
    prev = -1;
    ndone = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done4) begin
        ndone++;
        check("b2b_diff", {28'b0, diff4}, 32'h3);
        if (prev >= 0) check("b2b_spacing", cyc - prev, 32'd6);
        prev = cyc;
      end
    end
    start4 = 1'b0;
    check("b2b_done_count", ndone, 32'd3);
    for (int i = 0; i < 10 && (busy4 || done4); i++) @(negedge clk);
    @(negedge clk);
    check("b2b_idle", {30'b0, busy4, done4}, 32'd0);

    // Start pulsed during RUN must be ignored; previous diff stays visible.
    a4 = 4'h9; b4 = 4'h3; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("run_hold_diff", {28'b0, diff4}, 32'h3);
    a4 = 4'h1; b4 = 4'h7; bin4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("run_busy", {31'b0, busy4}, 32'd1);
    check("run_hold_diff2", {28'b0, diff4}, 32'h3);
    lat = 0;
    while (!done4 && lat < 40) begin @(negedge clk); lat++; end
    check("ignore_diff", {28'b0, diff4}, 32'h6);
    check("ignore_bout", {31'b0, bout4}, 32'd0);
    repeat (3) @(negedge clk);
    check("ignore_no_requeue", {30'b0, busy4, done4}, 32'd0);

    // Reset after two bits: abort, no done, outputs cleared.
    a4 = 4'h7; b4 = 4'h2; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, busy4}, 32'd0);
    check("abort_diff", {28'b0, diff4}, 32'd0);
    check("abort_bout", {31'b0, bout4}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", ndone, 32'd0);
    op(4, 8'h9, 8'h3, 1'b0, rd, rb, lat, bcnt);
    check("post_abort_diff", {24'b0, rd}, 32'h6);
    check("post_abort_bout", {31'b0, rb}, 32'd0);

    // Exhaustive WIDTH=4 sweep.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          op(4, 8'(x), 8'(y), c[0], rd, rb, lat, bcnt);
          exp9 = ref_sub(4, x, y, c);
          check("sweep4_diff", {24'b0, rd}, {24'b0, exp9[7:0]});
          check("sweep4_bout", {31'b0, rb}, {31'b0, exp9[8]});
        end

    // WIDTH=1: single RUN cycle, exhaustive.
    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        for (int c = 0; c < 2; c++) begin
          op(1, 8'(x), 8'(y), c[0], rd, rb, lat, bcnt);
          exp9 = ref_sub(1, x, y, c);
          check("w1_diff", {24'b0, rd}, {24'b0, exp9[7:0]});
          check("w1_bout", {31'b0, rb}, {31'b0, exp9[8]});
          check("w1_latency", lat, 32'd1);
        end

    // WIDTH=8: random sweep plus extremes.
    for (int i = 0; i < 40; i++) begin
      int x, y, c;
      x = (i == 0) ? 0 : (i == 1) ? 255 : int'($urandom_range(255));
      y = (i == 0) ? 255 : (i == 1) ? 0 : int'($urandom_range(255));
      c = (i < 2) ? 1 : int'($urandom_range(1));
      op(8, 8'(x), 8'(y), c[0], rd, rb, lat, bcnt);
      exp9 = ref_sub(8, x, y, c);
      check("w8_diff", {24'b0, rd}, {24'b0, exp9[7:0]});
      check("w8_bout", {31'b0, rb}, {31'b0, exp9[8]});
      check("w8_latency", lat, 32'd8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_nbit.md
Name: serial_subtractor_nbit

Overview:
- Bit-serial ripple subtractor. Computes diff = a - b - borrow_in over WIDTH clock cycles, one bit per cycle, LSB first, through a single registered borrow stage.
- Arithmetic inverse of the team's combinational ripple adder. Used where area matters more than latency, and as a cross-check partner for adder results.
- Start/busy/done handshake. The result is held stable in output registers until the next operation completes.

Parameters:
WIDTH, 4, operand/result width in bits; legal range >= 1.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  reset; synchronous and active-high (one clock, no other clock domains)
start  input  1  request pulse/level; sampled only in IDLE
a  input  WIDTH  minuend; sampled on the edge that accepts start
b  input  WIDTH  subtrahend; sampled on the edge that accepts start
borrow_in  input  1  initial borrow; sampled on the edge that accepts start
busy  output  1  high while state = RUN
done  output  1  one-cycle pulse, high while state = DONE
diff  output  WIDTH  registered result, valid from done onward
borrow_out  output  1  registered final borrow, valid from done onward

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - state=IDLE, busy=0, done=0, diff=0, borrow_out=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - Reset overrides all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: load a_sh<=a, b_sh<=b, br<=borrow_in, cnt<=0, and go to RUN.
  - Otherwise stay in IDLE.
- RUN: each edge processes bit cnt, using a0=a_sh[0] and b0=b_sh[0].
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d is shifted into the MSB of res_sh (right shift). a_sh and b_sh shift right. br<=br_next. cnt<=cnt+1.
  - On the edge processing bit WIDTH-1: diff<=final res_sh value (including that bit), borrow_out<=br_next, and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency:
  - If start is accepted at edge k, done is high in the cycle after edge k+WIDTH.
  - The next start can be accepted at edge k+WIDTH+2 at the earliest.
- start outside IDLE (in RUN or DONE) is ignored. It is not queued; a level start still high in IDLE is accepted then.
- a, b and borrow_in may change freely after acceptance; they do not affect the operation in flight.
- diff and borrow_out:
  - They change only on the completing edge or on reset, never during RUN.
  - The previous result remains readable throughout a new operation.
- Arithmetic is modulo 2^WIDTH. borrow_out=1 iff a < b + borrow_in (unsigned).
- Reset mid-RUN aborts the operation: no done pulse, and diff/borrow_out clear to 0.
- WIDTH=1: a single RUN cycle, then DONE.
- The counter is wide enough to hold WIDTH-1; no wrap occurs within an operation.

Test Plan:
- Reset, then a=9, b=3, borrow_in=0, start pulse -> busy high 4 cycles; done 4 edges after acceptance; diff=4'h6, borrow_out=0.
- a=3, b=9, borrow_in=0 -> diff=4'hA, borrow_out=1. a=0, b=0, borrow_in=1 -> diff=4'hF, borrow_out=1. a=F, b=F, borrow_in=1 -> diff=4'hF, borrow_out=1.
- Start held high continuously with a=5, b=2 -> back-to-back results 3,3,... Done pulses are spaced WIDTH+2 cycles apart; each done is a single cycle.
- Start pulsed during RUN with different operands -> ignored; result reflects the first operands only. Previous diff is held stable during RUN.
- Reset asserted mid-RUN (after 2 bits) -> next cycle state IDLE, busy=0, done never pulses, diff=0, borrow_out=0. A new start afterwards computes correctly.
- Exhaustive sweep of all a, b, borrow_in (512 cases, WIDTH=4) against a reference model. Also WIDTH=1 and WIDTH=8 builds with a random sweep.
